seg7_scan: RTL and testbench

Time-multiplexed 4-digit seven-segment driver and the display-side consumer of the packed 28-bit segment word built by the menu/scroll logic. It captures that word once per refresh frame into a shadow register to prevent tearing, then scans the four digits, driving one anode at a time. Each digit slot has an anti-ghosting blank window and a 3-bit brightness PWM. The outputs go straight to the board's anode and segment pins.

---
 rtl/seg7_scan.sv | 117 +++++++++++
 tb/tb_seg7_scan.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver: frame-latched shadow copy of the
// packed segment word, per-slot anti-ghosting blank window and 3-bit brightness PWM.
module seg7_scan #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] display,
    input  logic        enable,
    input  logic [2:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0)  ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_LIT   = 2'd2;

    logic [1:0]       st_q, st_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pwm_q, pwm_d;
    logic [27:0]      shadow_q, shadow_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [6:0]       digit_seg;
    logic             lit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        st_d         = st_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        frame_tick_d = 1'b0;
        pwm_d        = pwm_q + 3'd1;

        if (!enable) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
            idx_d = 2'd0;
        end else begin
            if (st_q == ST_IDLE) begin
                cnt_d        = '0;
                idx_d        = 2'd0;
                shadow_d     = display;
                frame_tick_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
                // Frame boundary: the only point besides IDLE exit where display is sampled.
                if (idx_q == 2'd3) begin
                    shadow_d     = display;
                    frame_tick_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            st_d = (cnt_d < BLANK_END) ? ST_BLANK : ST_LIT;
        end
    end

    always_comb begin
        digit_seg = shadow_q[6:0];
        case (idx_q)
            2'd1:    digit_seg = shadow_q[13:7];
            2'd2:    digit_seg = shadow_q[20:14];
            2'd3:    digit_seg = shadow_q[27:21];
            default: digit_seg = shadow_q[6:0];
        endcase
    end

    // Output pins are a registered function of the current state, hence one cycle behind it.
    assign lit   = (st_q == ST_LIT) && (pwm_q <= brightness);
    assign an_d  = (lit ? (4'b0001 << idx_q) : 4'b0000) ^ AN_OFF;
    assign seg_d = (lit ? digit_seg : 7'b0000000) ^ SEG_OFF;

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= ST_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            pwm_q        <= 3'd0;
            shadow_q     <= 28'd0;
            frame_tick_q <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
        end else begin
            st_q         <= st_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            shadow_q     <= shadow_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a cycle-age reference model predicts the pins of two
// instances (DIV=8/BLANK=2 and DIV=16/BLANK=0); a negedge monitor compares them.
module tb_seg7_scan;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] display = 28'h0EE7E3F;
    logic        enable = 1'b1;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        ft0, ft1;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: age = cycles since leaving idle, pwm = edges since reset.
    bit          m_run[2]    = '{0, 0};
    int          m_age[2]    = '{0, 0};
    logic [27:0] m_shadow[2] = '{28'd0, 28'd0};
    int          m_pwm       = 0;

    seg7_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut0 (
        .clk(clk), .rst(rst), .display(display), .enable(enable), .brightness(brightness),
        .an(an0), .seg(seg0), .frame_tick(ft0)
    );

    seg7_scan #(.REFRESH_DIV(16), .BLANK_CYCLES(0), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .display(display), .enable(enable), .brightness(brightness),
        .an(an1), .seg(seg1), .frame_tick(ft1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run[0]    = 0;
        m_run[1]    = 0;
        m_age[0]    = 0;
        m_age[1]    = 0;
        m_shadow[0] = 28'd0;
        m_shadow[1] = 28'd0;
        m_pwm       = 0;
    endtask

    task automatic model_step(input int i, input int div, input int blank);
        exp_t       e;
        logic [3:0] an_l;
        logic [6:0] seg_l;
        int         digit;
        an_l  = 4'd0;
        seg_l = 7'd0;
        if (m_run[i] && (m_age[i] % div) >= blank && (m_pwm % 8) <= int'(brightness)) begin
            digit = (m_age[i] / div) % 4;
            an_l  = 4'(1 << digit);
            seg_l = 7'((m_shadow[i] >> (7 * digit)) & 28'h7F);
        end
        e.an  = ~an_l;
        e.seg = ~seg_l;
        e.ft  = 1'b0;
        if (m_run[i]) begin
            if (!enable) begin
                m_run[i] = 0;
            end else begin
                m_age[i]++;
                if (m_age[i] % (4 * div) == 0) begin
                    m_shadow[i] = display;
                    e.ft        = 1'b1;
                end
            end
        end else if (enable) begin
            m_run[i]    = 1;
            m_age[i]    = 0;
            m_shadow[i] = display;
            e.ft        = 1'b1;
        end
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Stimulus side of the scoreboard: predict what the pins show after this edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
            if (clk) begin
                q0.push_back('{an: 4'hF, seg: 7'h7F, ft: 1'b0});
                q1.push_back('{an: 4'hF, seg: 7'h7F, ft: 1'b0});
            end
        end else begin
            model_step(0, 8, 2);
            model_step(1, 16, 0);
            m_pwm++;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check("dut0 an",  32'(an0),  32'(e.an));
            check("dut0 seg", 32'(seg0), 32'(e.seg));
            check("dut0 frame_tick", 32'(ft0), 32'(e.ft));
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("dut1 an",  32'(an1),  32'(e.an));
            check("dut1 seg", 32'(seg1), 32'(e.seg));
            check("dut1 frame_tick", 32'(ft1), 32'(e.ft));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int lit_cnt;
        int zero_seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Scan from reset, then change display while digit 1 is being shown.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (m_run[0] && (m_age[0] / 8) % 4 == 1 && m_age[0] < 32) found = 1;
        end
        check("reach slot 1", 32'(found), 32'd1);
        display = 28'hFFFFFFF;
        repeat (48) @(negedge clk);

        // Random display words and brightness levels.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ($urandom_range(3, 0) == 0) display = 28'($urandom);
            if ($urandom_range(7, 0) == 0) brightness = 3'($urandom_range(7, 0));
        end

        // PWM duty on the 16-cycle, no-blank instance.
        brightness = 3'd0;
        repeat (2) @(negedge clk);
        lit_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an1 != 4'hF) lit_cnt++;
        end
        check("pwm lit cycles b=0", 32'(lit_cnt), 32'd2);
        brightness = 3'd3;
        repeat (2) @(negedge clk);
        lit_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (an1 != 4'hF) lit_cnt++;
        end
        check("pwm lit cycles b=3", 32'(lit_cnt), 32'd8);

        // Drop enable at digit 2, count 5.
        brightness = 3'd7;
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(negedge clk);
            if (m_run[0] && m_age[0] % 32 == 21) found = 1;
        end
        check("reach idx2 cnt5", 32'(found), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("idx after drop", 32'(dut0.idx_q), 32'd0);
        check("cnt after drop", 32'(dut0.cnt_q), 32'd0);
        repeat (10) @(negedge clk);
        display = 28'($urandom);
        enable  = 1'b1;
        repeat (80) @(negedge clk);

        // Asynchronous reset between edges while a digit is lit.
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an0 != 4'hF) found = 1;
        end
        check("lit before reset", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst an",  32'(an0),  32'hF);
        check("async rst seg", 32'(seg0), 32'h7F);
        check("async rst frame_tick", 32'(ft0), 32'd0);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);

        // Digit 1 blank: anode active, segments all off.
        display = {14'($urandom), 7'h00, 7'($urandom)};
        zero_seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (an0 == 4'b1101 && seg0 == 7'h7F) zero_seen++;
        end
        check("zero digit shown", 32'(zero_seen >= 6), 32'd1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
